// File: rtl/prbs_cfg_if.sv
// Configuration handshake bundle between the button controller and the PRBS
// generator. The controller drives the configuration and valid; the
// generator answers with ready.
interface prbs_cfg_if #(
  parameter int MODE_W  = 2,
  parameter int SPEED_W = 3
) ();
  logic [MODE_W-1:0]  cfg_mode;
  logic [SPEED_W-1:0] cfg_speed;
  logic               cfg_run;
  logic               cfg_reseed;
  logic               cfg_valid;
  logic               cfg_ready;

  modport master (
    output cfg_mode, cfg_speed, cfg_run, cfg_reseed, cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_mode, cfg_speed, cfg_run, cfg_reseed, cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/prbs_btn_ctrl.sv
// Front-panel controller for the PRBS LED design. Three raw buttons are
// synchronised, debounced and classified as short or long presses. The
// resulting events are latched in sticky pending bits, arbitrated by fixed
// priority and turned into one configuration transaction each.
module prbs_btn_ctrl #(
  parameter int DEB_CNT    = 1024,
  parameter int LONG_CNT   = 1000000,
  parameter int NUM_MODES  = 4,
  parameter int NUM_SPEEDS = 8,
  parameter int SPEED_RST  = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   btn,
  prbs_cfg_if.master   cfg
);

  localparam int MODE_W  = (NUM_MODES  > 1) ? $clog2(NUM_MODES)  : 1;
  localparam int SPEED_W = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1;
  localparam int DEB_W   = (DEB_CNT    > 1) ? $clog2(DEB_CNT)    : 1;
  localparam int LONG_W  = (LONG_CNT   > 1) ? $clog2(LONG_CNT)   : 1;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  // Pending bit layout: {L2,S2,L1,S1,L0,S0}; higher index = higher priority.
  logic [2:0]         short_evt;
  logic [2:0]         long_evt;
  logic [5:0]         set_vec;
  logic [5:0]         pend_reg;
  logic [5:0]         grant;
  logic [5:0]         clr_vec;

  logic [1:0]         state_reg;
  logic [MODE_W-1:0]  mode_reg;
  logic [SPEED_W-1:0] speed_reg;
  logic               run_reg;
  logic               reseed_reg;
  logic               valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic              sync1_reg;
      logic              sync2_reg;
      logic              stable_reg;
      logic              stable_d_reg;
      logic              long_done_reg;
      logic [DEB_W-1:0]  deb_cnt_reg;
      logic [LONG_W-1:0] hold_cnt_reg;
      logic              flip;
      logic              flip_up;
      logic              long_hit;

      // The DEB_CNT-th consecutive disagreement flips the debounced state.
      assign flip     = (sync2_reg != stable_reg) && (deb_cnt_reg == DEB_W'(DEB_CNT - 1));
      assign flip_up  = flip && !stable_reg;
      // Long fires once per press, on the cycle the hold count saturates.
      assign long_hit = stable_reg && (hold_cnt_reg == LONG_W'(LONG_CNT - 1)) && !long_done_reg;

      assign long_evt[gi]    = long_hit;
      assign short_evt[gi]   = stable_d_reg && !stable_reg && !long_done_reg;
      assign set_vec[2*gi]   = short_evt[gi];
      assign set_vec[2*gi+1] = long_evt[gi];

      // Two-flop synchroniser for the asynchronous button input.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= btn[gi];
          sync2_reg <= sync1_reg;
        end
      end

      // Debounce: count consecutive disagreeing cycles, flip on the last one.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stable_reg  <= 1'b0;
          deb_cnt_reg <= '0;
        end else if (sync2_reg != stable_reg) begin
          if (flip) begin
            stable_reg  <= ~stable_reg;
            deb_cnt_reg <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
          end
        end else begin
          deb_cnt_reg <= '0;
        end
      end

      // Hold counter and long-press bookkeeping; both restart on a new press.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stable_d_reg  <= 1'b0;
          hold_cnt_reg  <= '0;
          long_done_reg <= 1'b0;
        end else begin
          stable_d_reg <= stable_reg;
          if (flip_up) begin
            hold_cnt_reg  <= '0;
            long_done_reg <= 1'b0;
          end else begin
            if (stable_reg && (hold_cnt_reg != LONG_W'(LONG_CNT - 1)))
              hold_cnt_reg <= hold_cnt_reg + LONG_W'(1);
            if (long_hit)
              long_done_reg <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // Fixed-priority arbiter: the highest set pending bit wins.
  always_comb begin
    grant = '0;
    for (int i = 0; i < 6; i++) begin
      if (pend_reg[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  assign clr_vec = (state_reg == ST_IDLE) ? grant : 6'd0;

  // Sticky pending bits; a new event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pend_reg <= '0;
    else
      pend_reg <= (pend_reg & ~clr_vec) | set_vec;
  end

  // Transaction FSM: announce reset config, then one event per transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_INIT;
      mode_reg   <= '0;
      speed_reg  <= SPEED_W'(SPEED_RST);
      run_reg    <= 1'b1;
      reseed_reg <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          valid_reg <= 1'b1;
          state_reg <= ST_SEND;
        end
        ST_IDLE: begin
          if (|pend_reg) begin
            valid_reg  <= 1'b1;
            state_reg  <= ST_SEND;
            reseed_reg <= 1'b0;
            if (grant[5]) begin
              run_reg    <= 1'b1;
              reseed_reg <= 1'b1;
            end else if (grant[4]) begin
              run_reg <= ~run_reg;
            end else if (grant[3]) begin
              speed_reg <= SPEED_W'(SPEED_RST);
            end else if (grant[2]) begin
              speed_reg <= (speed_reg == SPEED_W'(NUM_SPEEDS - 1)) ? '0 : speed_reg + SPEED_W'(1);
            end else if (grant[1]) begin
              mode_reg <= '0;
            end else begin
              mode_reg <= (mode_reg == MODE_W'(NUM_MODES - 1)) ? '0 : mode_reg + MODE_W'(1);
            end
          end
        end
        ST_SEND: begin
          if (cfg.cfg_ready) begin
            valid_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cfg.cfg_mode   = mode_reg;
  assign cfg.cfg_speed  = speed_reg;
  assign cfg.cfg_run    = run_reg;
  assign cfg.cfg_reseed = reseed_reg;
  assign cfg.cfg_valid  = valid_reg;

endmodule
